// File: rtl/rv32i_types.sv
// Shared fetch-stage types: FSM state encoding, buffer entry layout and the NOP encoding.
package rv32i_types;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of {pc, ir} entries with a combinational head; push at full is
// accepted only together with a pop.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory request FSM feeding a small buffer.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the outputs when the buffer is empty.
module instr_fetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out,
    output logic        load_out,
    output logic        flush_out
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_nxt;
    logic [31:0]      req_addr_nxt;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     wdata;
    logic [OCC_W-1:0] occ_nxt;
    logic             space;
    logic             bypass_hit;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = (state == FETCH) & imem_resp & ~redirect & empty & ~stall;
`else
    assign bypass_hit = 1'b0;
`endif

    // Buffer control and decode-facing outputs; redirect overrides any push or pop.
    always_comb begin
        wdata     = '{pc: fetch_pc, ir: imem_rdata};
        push      = (state == FETCH) & imem_resp & ~redirect & ~bypass_hit & (~full | pop);
        pop       = ~empty & ~stall & ~redirect;
        occ_nxt   = OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
        space     = (occ_nxt < OCC_W'(DEPTH));
        if_valid  = ~empty | bypass_hit;
        ir_out    = NOP_INSTR;
        pc_out    = '0;
        if (bypass_hit) begin
            ir_out = imem_rdata;
            pc_out = fetch_pc;
        end else if (!empty) begin
            ir_out = head.ir;
            pc_out = head.pc;
        end
        load_out  = if_valid & ~stall;
        flush_out = redirect | (~if_valid & ~stall);
    end

    // Next-state logic; fetch_pc is the address of the outstanding or next request.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt = align_word(redirect_pc);
                    state_nxt    = FETCH;
                end else if (space) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    fetch_pc_nxt = align_word(redirect_pc);
                    state_nxt    = imem_resp ? FETCH : DRAIN;
                end else if (imem_resp) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    state_nxt    = space ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                if (redirect) fetch_pc_nxt = align_word(redirect_pc);
                if (imem_resp) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
        req_addr_nxt = (state_nxt == FETCH) ? fetch_pc_nxt : imem_address;
    end

    // DRAIN keeps imem_address on the abandoned request until its response lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            imem_address <= RESET_PC;
            imem_read    <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            imem_address <= req_addr_nxt;
            imem_read    <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, address of first fetch after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 imem_read  output  1  instruction memory read request, held until imem_resp.
REQ-006 imem_address  output  32  word-aligned fetch address, stable while imem_read=1.
REQ-007 imem_rdata  input  32  fetched instruction, valid when imem_resp=1.
REQ-008 imem_resp  input  1  one-cycle response strobe completing the outstanding request.
REQ-009 stall  input  1  decode-stage register cannot accept; hold buffer head.
REQ-010 redirect  input  1  taken branch/jump; discard all fetched and in-flight instructions.
REQ-011 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-012 if_valid  output  1  ir_out/pc_out hold a real instruction.
REQ-013 ir_out  output  32  head instruction; 32'h00000013 (NOP) when if_valid=0.
REQ-014 pc_out  output  32  head PC; 0 when if_valid=0.
REQ-015 load_out  output  1  drives decode-register load; equals if_valid & ~stall.
REQ-016 flush_out  output  1  drives decode-register flush; equals redirect | (~if_valid & ~stall).

Function
REQ-017 FSM states SHALL be IDLE (no request), FETCH (request outstanding), DRAIN (outstanding response to be discarded).
REQ-018 IDLE->FETCH SHALL occur when buffer occupancy < DEPTH; imem_read asserts in FETCH and DRAIN only.
REQ-019 At most one request SHALL be outstanding; a new request SHALL issue only if occupancy after the current cycle's push/pop leaves a free entry.
REQ-020 On imem_resp in FETCH, {fetch_pc, imem_rdata} SHALL push into the buffer and fetch_pc SHALL advance by 4 (32-bit wrap, 32'hFFFFFFFC -> 0).
REQ-021 After a response, FETCH SHALL remain FETCH (back-to-back, no bubble) if space remains, else go IDLE.
REQ-022 Head pops when if_valid & ~stall; simultaneous push and pop at full SHALL be permitted and leave occupancy unchanged.
REQ-023 redirect SHALL empty the buffer, set fetch_pc = {redirect_pc[31:2],2'b00}, and override any same-cycle push or pop.
REQ-024 redirect in FETCH without same-cycle imem_resp SHALL go DRAIN; with same-cycle imem_resp the response is dropped and state goes FETCH at the new PC.
REQ-025 In DRAIN imem_address SHALL hold the old address; imem_resp is discarded, then FETCH at the redirected PC.
REQ-026 redirect in DRAIN SHALL update fetch_pc only and remain DRAIN.
REQ-027 redirect in IDLE SHALL go FETCH next cycle at the new PC.
REQ-028 Buffer read-to-output latency SHALL be zero (head is combinational); response-to-if_valid latency SHALL be one cycle.

Reset
REQ-029 While rst=0: state IDLE, occupancy 0, fetch_pc=RESET_PC, imem_read=0, if_valid=0, ir_out=NOP, pc_out=0, load_out=0.
REQ-030 Reset asserted mid-request SHALL abandon it; an imem_resp arriving after reset release while IDLE SHALL be ignored.
REQ-031 First request (imem_address=RESET_PC) SHALL issue the first clk edge after rst deasserts.

Configuration
REQ-032 Macro FETCH_BYPASS_EN: when defined, an imem_resp with empty buffer and ~stall SHALL drive ir_out/pc_out/if_valid in the same cycle without being stored; when undefined, all responses go through the buffer (REQ-028 latency).

Structure
REQ-033 fetch_state_t enum and NOP_INSTR constant (32'h00000013) SHALL live in package rv32i_types.
REQ-034 Buffer SHALL be sub-module fetch_fifo (DEPTH entries of {pc, ir}, push/pop/clear, full/empty, head outputs).

Verification
REQ-035 Reset release, imem_resp every second cycle with rdata=A,B,C, stall=0 -> addresses 0,4,8; pc_out/ir_out 0/A, 4/B, 8/C, each one cycle after resp.
REQ-036 stall=1 for 6 cycles with DEPTH=2 -> two entries buffered, imem_read drops, IDLE; stall release pops 0 then 4, next request at 8.
REQ-037 redirect to 32'h00000103 while request outstanding -> DRAIN, response discarded, next imem_address 32'h00000100, flush_out=1 that cycle.
REQ-038 redirect coincident with imem_resp -> response not seen on ir_out, next request at redirect PC, no DRAIN.
REQ-039 fetch_pc at 32'hFFFFFFFC, resp -> next imem_address 32'h00000000.
REQ-040 rst=0 asserted with request outstanding, late imem_resp after release -> ignored; first output instruction has pc_out=RESET_PC.
